// File: rtl/cloud_pkg.sv
// -----------------------------------------------------------------------------
// cloud_pkg
// Shared types and constants for the cloud subsystem: the spawner state
// encoding, playfield/cloud geometry and the pseudo-random ranges used when a
// new cloud is launched.
// No ports (package).
// -----------------------------------------------------------------------------
package cloud_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        PENDING,
        CRASHED
    } spawner_state_t;

    localparam int          CLOUD_WIDTH = 46;
    localparam int          GAME_WIDTH  = 640;
    localparam int          LEVEL_RANGE = 42;
    localparam int          GAP_RANGE   = 301;
    localparam int          POS_WIDTH   = 11;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit right-shifting Galois LFSR. Advances one step on each cycle where
// 'step' is high; returns to SEED on reset.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous reset, active low
//   step  - advance by one step this cycle
//   value - current LFSR contents
// -----------------------------------------------------------------------------
module lfsr16
    import cloud_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] value
);

    // When the bit shifted out is 1, the tap mask is folded back in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= SEED;
        end else if (step) begin
            value <= value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);
        end
    end

endmodule

// File: rtl/cloud_spawner.sv
// -----------------------------------------------------------------------------
// cloud_spawner
// Decides when and into which slot a new cloud is launched. The cloud
// instances live outside; this block only tracks which slots are busy,
// requests a start on one free slot and broadcasts the random sky level and
// gap offsets that the started cloud latches.
// Ports:
//   clk, rst      - clock; asynchronous active-low reset
//   update        - one-cycle per-frame pulse
//   start, crash  - game status levels
//   slot_remove   - per-slot "cloud left the screen" flags
//   slot_x_pos    - per-slot signed x position, 11 bits each
//   slot_gap      - per-slot gap, 11 bits each
//   slot_start    - per-slot start request (one-hot or zero)
//   level_rand    - sky level offset, 0..41
//   gap_rand      - gap offset, 0..300
//   active_count  - number of busy slots (registered)
// -----------------------------------------------------------------------------
module cloud_spawner
    import cloud_pkg::*;
#(
    parameter int          NUM_CLOUDS = 6,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            update,
    input  logic                            start,
    input  logic                            crash,
    input  logic [NUM_CLOUDS-1:0]           slot_remove,
    input  logic [NUM_CLOUDS*POS_WIDTH-1:0] slot_x_pos,
    input  logic [NUM_CLOUDS*POS_WIDTH-1:0] slot_gap,
    output logic [NUM_CLOUDS-1:0]           slot_start,
    output logic [9:0]                      level_rand,
    output logic [10:0]                     gap_rand,
    output logic [3:0]                      active_count
);

    localparam int IDX_W = (NUM_CLOUDS > 1) ? $clog2(NUM_CLOUDS) : 1;
    localparam logic signed [12:0] CLOUD_W13 = 13'(CLOUD_WIDTH);
    localparam logic signed [12:0] GAME_W13  = 13'(GAME_WIDTH);

    spawner_state_t          state, state_next;
    logic [NUM_CLOUDS-1:0]   busy;
    logic [NUM_CLOUDS-1:0]   consume_mask;
    logic [IDX_W-1:0]        last, pend_slot, free_slot;
    logic                    free_any;
    logic                    load_pending;
    logic                    consume;
    logic                    spawn_ok;
    logic [15:0]             lfsr;
    logic [POS_WIDTH-1:0]    x_raw, gap_raw;
    logic signed [12:0]      x_last, gap_last, reach;
    logic [3:0]              busy_count;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (update),
        .value (lfsr)
    );

    // Geometry of the most recently launched cloud. x is sign-extended and
    // the gap zero-extended into 13 bits so off-screen (negative) positions
    // compare correctly instead of wrapping to large values.
    assign x_raw    = slot_x_pos[int'(last)*POS_WIDTH +: POS_WIDTH];
    assign gap_raw  = slot_gap[int'(last)*POS_WIDTH +: POS_WIDTH];
    assign x_last   = {{2{x_raw[POS_WIDTH-1]}}, x_raw};
    assign gap_last = {2'b00, gap_raw};
    assign reach    = x_last + CLOUD_W13 + gap_last;

    // Lowest-index free slot: scanning downward lets the lowest index win.
    always_comb begin
        free_any  = 1'b0;
        free_slot = '0;
        for (int i = NUM_CLOUDS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_any  = 1'b1;
                free_slot = IDX_W'(i);
            end
        end
    end

    // An empty sky always spawns; otherwise the last cloud must have moved
    // far enough left and the LFSR must agree.
    assign spawn_ok = free_any && ((busy == '0) || ((reach < GAME_W13) && lfsr[0]));

    always_comb begin
        busy_count = '0;
        for (int i = 0; i < NUM_CLOUDS; i++) begin
            busy_count = busy_count + 4'(busy[i]);
        end
    end

    // Next-state logic. The very first cloud skips EVAL so its request
    // appears the cycle right after the update. Crash overrides everything.
    always_comb begin
        state_next   = state;
        load_pending = 1'b0;
        consume      = 1'b0;
        case (state)
            IDLE: begin
                if (update && start) begin
                    if (busy == '0) begin
                        state_next   = PENDING;
                        load_pending = 1'b1;
                    end else begin
                        state_next = EVAL;
                    end
                end
            end
            EVAL: begin
                if (spawn_ok) begin
                    state_next   = PENDING;
                    load_pending = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            PENDING: begin
                if (update) begin
                    consume    = 1'b1;
                    state_next = IDLE;
                end
            end
            CRASHED: state_next = CRASHED;
            default: state_next = IDLE;
        endcase
        if (crash) begin
            state_next   = CRASHED;
            load_pending = 1'b0;
            consume      = 1'b0;
        end
    end

    // The request is decoded from the state register, so an async reset
    // drops it at once; crash masks it combinationally.
    always_comb begin
        slot_start = '0;
        if (state == PENDING && !crash) begin
            slot_start[pend_slot] = 1'b1;
        end
    end

    always_comb begin
        consume_mask = '0;
        if (consume) begin
            consume_mask[pend_slot] = 1'b1;
        end
    end

    // State, slot bookkeeping and the latched random offsets. A consume
    // sets its busy bit even if the same slot reports remove that cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            busy         <= '0;
            last         <= '0;
            pend_slot    <= '0;
            level_rand   <= '0;
            gap_rand     <= '0;
            active_count <= '0;
        end else begin
            state        <= state_next;
            busy         <= (busy & ~slot_remove) | consume_mask;
            active_count <= busy_count;
            if (consume) begin
                last <= pend_slot;
            end
            if (load_pending) begin
                pend_slot  <= free_slot;
                level_rand <= 10'(lfsr % 16'(LEVEL_RANGE));
                gap_rand   <= 11'((lfsr >> 6) % 16'(GAP_RANGE));
            end
        end
    end

endmodule

// File: tb/tb_cloud_spawner.sv
// -----------------------------------------------------------------------------
// tb_cloud_spawner
// Self-checking bench for cloud_spawner: directed frames with hand-computed
// expectations, a table of spawn-geometry vectors, crash/reset corner cases
// and a long randomised run checked against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_cloud_spawner;

    localparam int          N    = 6;
    localparam logic [15:0] SEED = 16'hACE1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              update = 1'b0;
    logic              start = 1'b0;
    logic              crash = 1'b0;
    logic [N-1:0]      slot_remove = '0;
    logic [N*11-1:0]   slot_x_pos = '0;
    logic [N*11-1:0]   slot_gap = '0;
    logic [N-1:0]      slot_start;
    logic [9:0]        level_rand;
    logic [10:0]       gap_rand;
    logic [3:0]        active_count;

    int checks = 0;
    int errors = 0;

    // Reference model state, advanced once per frame.
    logic [15:0] m_lfsr;
    logic [N-1:0] m_busy;
    int          m_last;
    bit          m_pend;
    int          m_k;
    bit          m_crashed;
    logic [9:0]  m_level;
    logic [10:0] m_gap;

    typedef struct {
        int x;
        int gap;
        bit fits;
    } vec_t;

    vec_t vecs[9];

    cloud_spawner #(.NUM_CLOUDS(N), .LFSR_SEED(SEED)) dut (
        .clk          (clk),
        .rst          (rst),
        .update       (update),
        .start        (start),
        .crash        (crash),
        .slot_remove  (slot_remove),
        .slot_x_pos   (slot_x_pos),
        .slot_gap     (slot_gap),
        .slot_start   (slot_start),
        .level_rand   (level_rand),
        .gap_rand     (gap_rand),
        .active_count (active_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] lfsrNext(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic int lowestFree();
        for (int i = 0; i < N; i++) begin
            if (!m_busy[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit geoFits();
        logic signed [10:0] xs;
        int v;
        xs = slot_x_pos[m_last*11 +: 11];
        v  = int'(xs) + 46 + int'(slot_gap[m_last*11 +: 11]);
        return v < 640;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        m_lfsr    = SEED;
        m_busy    = '0;
        m_last    = 0;
        m_pend    = 0;
        m_k       = 0;
        m_crashed = 0;
    endtask

    task automatic setAll(input int x, input int g);
        for (int i = 0; i < N; i++) begin
            slot_x_pos[i*11 +: 11] = 11'(x);
            slot_gap[i*11 +: 11]   = 11'(g);
        end
    endtask

    task automatic modelLoad();
        m_level = 10'(m_lfsr % 42);
        m_gap   = 11'((m_lfsr >> 6) % 301);
    endtask

    // One frame: update pulse, then one extra cycle for EVAL, then compare.
    task automatic applyStimulus();
        logic [N-1:0] exp_start;
        update = 1'b1;
        tick();
        update = 1'b0;
        if (m_crashed) begin
            m_lfsr = lfsrNext(m_lfsr);
        end else if (m_pend) begin
            m_busy[m_k] = 1'b1;
            m_last = m_k;
            m_pend = 0;
            m_lfsr = lfsrNext(m_lfsr);
        end else if (start) begin
            if (m_busy == '0) begin
                m_pend = 1;
                m_k = 0;
                modelLoad();
                m_lfsr = lfsrNext(m_lfsr);
            end else begin
                m_lfsr = lfsrNext(m_lfsr);
                if (lowestFree() >= 0 && geoFits() && m_lfsr[0]) begin
                    m_pend = 1;
                    m_k = lowestFree();
                    modelLoad();
                end
            end
        end else begin
            m_lfsr = lfsrNext(m_lfsr);
        end
        tick();
        exp_start = '0;
        if (m_pend) exp_start[m_k] = 1'b1;
        checkOutput("slot_start", 32'(slot_start), 32'(exp_start));
        if (m_pend) begin
            checkOutput("level_rand", 32'(level_rand), 32'(m_level));
            checkOutput("gap_rand", 32'(gap_rand), 32'(m_gap));
        end
        checkOutput("active_count", 32'(active_count), 32'($countones(m_busy)));
    endtask

    task automatic removeSlots(input logic [N-1:0] mask);
        slot_remove = mask;
        tick();
        slot_remove = '0;
        m_busy = m_busy & ~mask;
        tick();
    endtask

    initial begin
        int n;
        bit seen0, seen1;
        logic [15:0] nx;
        logic [N-1:0] exp_s;
        logic [N-1:0] rmask;

        vecs[0] = '{600, 200, 1'b0};
        vecs[1] = '{300, 250, 1'b1};
        vecs[2] = '{0, 593, 1'b1};
        vecs[3] = '{0, 594, 1'b0};
        vecs[4] = '{-46, 0, 1'b1};
        vecs[5] = '{-1024, 2047, 1'b0};
        vecs[6] = '{-1024, 1500, 1'b1};
        vecs[7] = '{1023, 0, 1'b0};
        vecs[8] = '{547, 46, 1'b1};

        // Reset state
        modelReset();
        tick();
        tick();
        checkOutput("rst_slot_start", 32'(slot_start), 0);
        checkOutput("rst_level_rand", 32'(level_rand), 0);
        checkOutput("rst_gap_rand", 32'(gap_rand), 0);
        checkOutput("rst_active_count", 32'(active_count), 0);
        rst = 1'b1;

        // First cloud: slot 0, offsets from the seed (44257 % 42 = 31, 691 % 301 = 89)
        start = 1'b1;
        setAll(600, 200);
        applyStimulus();
        checkOutput("first_slot_start", 32'(slot_start), 32'h01);
        checkOutput("first_level", 32'(level_rand), 31);
        checkOutput("first_gap", 32'(gap_rand), 89);
        applyStimulus();
        checkOutput("consume_count", 32'(active_count), 1);

        // Game not started: no evaluation
        start = 1'b0;
        applyStimulus();
        checkOutput("nostart_slot_start", 32'(slot_start), 0);
        start = 1'b1;

        // Last cloud too far right: never spawns
        for (int f = 0; f < 20; f++) begin
            applyStimulus();
            checkOutput("far_right_none", 32'(slot_start), 0);
        end

        // Geometry table, one slot busy, all slots share x/gap
        for (int v = 0; v < 9; v++) begin
            setAll(vecs[v].x, vecs[v].gap);
            nx = lfsrNext(m_lfsr);
            exp_s = (vecs[v].fits && nx[0]) ? 6'b000010 : 6'b000000;
            applyStimulus();
            checkOutput($sformatf("vec%0d_slot_start", v), 32'(slot_start), 32'(exp_s));
            if (m_pend) begin
                applyStimulus();
                removeSlots(6'b000010);
            end
        end

        // x=300, gap=250: spawn exactly when lfsr[0] is 1
        setAll(300, 250);
        seen0 = 0;
        seen1 = 0;
        n = 0;
        while (!(seen0 && seen1) && n < 40) begin
            nx = lfsrNext(m_lfsr);
            applyStimulus();
            checkOutput("lfsr_gate", 32'(slot_start), nx[0] ? 32'h02 : 32'h00);
            if (nx[0]) seen1 = 1; else seen0 = 1;
            if (m_pend) begin
                applyStimulus();
                removeSlots(6'b000010);
            end
            n++;
        end

        // Fill every slot
        setAll(0, 0);
        n = 0;
        while (!(m_busy == '1 && !m_pend) && n < 200) begin
            applyStimulus();
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("[TB] FAIL fill_timeout: got %0d busy expected %0d", $countones(m_busy), N);
        end
        applyStimulus();
        checkOutput("full_none", 32'(slot_start), 0);
        checkOutput("full_count", 32'(active_count), 6);
        removeSlots(6'b000100);
        checkOutput("remove_count", 32'(active_count), 5);
        n = 0;
        while (!m_pend && n < 50) begin
            applyStimulus();
            n++;
        end
        checkOutput("refill_slot2", 32'(slot_start), 32'h04);
        applyStimulus();

        // Crash while a request is pending
        removeSlots(6'b010000);
        n = 0;
        while (!m_pend && n < 50) begin
            applyStimulus();
            n++;
        end
        checkOutput("pre_crash_slot4", 32'(slot_start), 32'h10);
        crash = 1'b1;
        #1;
        checkOutput("crash_comb_drop", 32'(slot_start), 0);
        tick();
        crash = 1'b0;
        m_crashed = 1;
        m_pend = 0;
        for (int f = 0; f < 50; f++) begin
            applyStimulus();
            checkOutput("crashed_none", 32'(slot_start), 0);
        end
        rst = 1'b0;
        #1;
        checkOutput("crash_rst_count", 32'(active_count), 0);
        checkOutput("crash_rst_level", 32'(level_rand), 0);
        tick();
        rst = 1'b1;
        modelReset();
        applyStimulus();
        checkOutput("reseed_slot0", 32'(slot_start), 32'h01);
        checkOutput("reseed_level", 32'(level_rand), 31);
        checkOutput("reseed_gap", 32'(gap_rand), 89);

        // Reset in the middle of PENDING: request drops at once, no consume
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_drop", 32'(slot_start), 0);
        tick();
        rst = 1'b1;
        modelReset();
        tick();
        checkOutput("no_partial_consume", 32'(active_count), 0);
        applyStimulus();
        checkOutput("after_rst_slot0", 32'(slot_start), 32'h01);
        applyStimulus();

        // Randomised frames against the model
        for (int f = 0; f < 10000; f++) begin
            for (int i = 0; i < N; i++) begin
                slot_x_pos[i*11 +: 11] = 11'($urandom);
                slot_gap[i*11 +: 11]   = 11'($urandom_range(0, 600));
            end
            if ($urandom_range(0, 3) == 0) begin
                rmask = N'($urandom & $urandom & $urandom);
                removeSlots(rmask);
            end
            exp_s = m_busy;
            applyStimulus();
            checkOutput("rand_onehot", 32'($countones(slot_start) <= 1), 1);
            checkOutput("rand_level_range", 32'(level_rand <= 10'd41), 1);
            checkOutput("rand_gap_range", 32'(gap_rand <= 11'd300), 1);
            checkOutput("rand_not_busy", 32'(slot_start & exp_s), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cloud_spawner.md
CLOUD_SPAWNER -- requirements
Module: cloud_spawner

Interface
REQ-001 Parameter NUM_CLOUDS, default 6, number of cloud slots managed.
REQ-002 Parameter LFSR_SEED, default 16'hACE1, non-zero LFSR reset value.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 update  input  1  per-frame update pulse, one cycle, shared with all cloud slots.
REQ-006 start  input  1  game started; level-sensitive.
REQ-007 crash  input  1  game crashed; level-sensitive.
REQ-008 slot_remove  input  NUM_CLOUDS  per-slot remove flag from each cloud instance.
REQ-009 slot_x_pos  input  NUM_CLOUDS x 11 signed  per-slot x_pos, slot i at bits [11i+10:11i].
REQ-010 slot_gap  input  NUM_CLOUDS x 11  per-slot gap.
REQ-011 slot_start  output  NUM_CLOUDS  per-slot start request, at most one bit set.
REQ-012 level_rand  output  10  sky-level offset broadcast to all slots, range 0..41.
REQ-013 gap_rand  output  11  gap offset broadcast to all slots, range 0..300.
REQ-014 active_count  output  4  number of busy slots.

Function
REQ-015 FSM states: IDLE, EVAL, PENDING, CRASHED.
REQ-016 IDLE: on update && start, go to PENDING, requesting slot 0 (first cloud unconditional).
REQ-017 EVAL: entered the cycle after each update while not PENDING/CRASHED; evaluates spawn, then goes to PENDING (spawn) or IDLE (no spawn), one cycle only.
REQ-018 Spawn condition: a free slot exists AND (no slot busy OR (x_last + 46 + gap_last < 640 AND lfsr[0]==1)), with x_last/gap_last from the slot most recently spawned.
REQ-019 Comparison uses 13-bit signed arithmetic; no wrap for negative x_pos.
REQ-020 Chosen slot: lowest-index slot that is neither busy nor pending.
REQ-021 PENDING: slot_start[k] held high; level_rand/gap_rand held stable; on next update, slot k marked busy, last := k, slot_start cleared, go to IDLE.
REQ-022 A slot consumed on an update is not re-evaluated in that frame; the next evaluation follows the next update.
REQ-023 busy[i] clears when slot_remove[i]==1; set-on-consume has priority over clear in the same cycle.
REQ-024 All slots busy: no spawn; stay IDLE.
REQ-025 crash (any state): next state CRASHED, slot_start forced 0 combinationally the same cycle; CRASHED exits only by reset.
REQ-026 LFSR: 16-bit Galois, taps 16'hB400, advances one step per update cycle only.
REQ-027 On entering PENDING: level_rand := lfsr % 42, gap_rand := (lfsr >> 6) % 301, both from the current LFSR value.
REQ-028 active_count = popcount(busy), registered, one-cycle latency.

Reset
REQ-029 On rst low: state IDLE, busy 0, last 0, slot_start 0, level_rand 0, gap_rand 0, active_count 0, LFSR := LFSR_SEED.
REQ-030 Reset asserted mid-PENDING drops slot_start immediately (asynchronously), with no partial consume.

Structure
REQ-031 cloud_pkg SHALL gain: spawner state enum, CLOUD_WIDTH 46, GAME_WIDTH 640, LEVEL_RANGE 42, GAP_RANGE 301, LFSR_TAPS.
REQ-032 LFSR SHALL be a sub-module lfsr16 (clk, rst, step, seed parameter, 16-bit value out).
REQ-033 Cloud instances SHALL be external; the spawner only drives and observes the slot buses.

Verification
REQ-034 Reset, start=1, first update -> slot_start=000001 next cycle; level_rand<=41, gap_rand<=300.
REQ-035 Slot0 consumed, slot_x_pos[0]=600, gap 200 -> no spawn over 20 updates.
REQ-036 slot_x_pos[0]=300, gap 250, lfsr[0]=1 -> slot_start=000010 after EVAL; with lfsr[0]=0 -> none.
REQ-037 All 6 busy -> no request; raise slot_remove[2] -> busy[2] clears, next spawn targets slot 2, active_count drops 6->5.
REQ-038 crash during PENDING -> slot_start=0 same cycle, CRASHED held for 50 updates; rst low -> IDLE, LFSR reseeded.
REQ-039 Randomised: 10000 frames -> at most one slot_start bit, outputs in range, no spawn into a busy slot.
